// File: rtl/reg_check_harness.sv
// End-of-run architectural register checker: waits NUM_CYCLES, then takes regfile port A and compares a preloaded table.
// Optional mismatch log enabled by defining REG_CHECK_FAIL_LOG_EN; without it fail_* are tied to 0.
module reg_check_harness #(
   parameter int NUM_CYCLES = 255,
   parameter int MAX_CHECKS = 32,
   localparam int AW = $clog2(MAX_CHECKS)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic          exp_we,
   input  logic [AW-1:0] exp_waddr,
   input  logic [4:0]    exp_wreg,
   input  logic [31:0]   exp_wdata,
   input  logic [6:0]    exp_count,
   input  logic [31:0]   data_readRegA,
   output logic          test_mode,
   output logic [4:0]    ctrl_readRegA_test,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [6:0]    error_count,
   // fail_valid is a one-cycle strobe with no ready; fail_reg/exp/act are qualified by it and hold afterwards.
   output logic          fail_valid,
   output logic [4:0]    fail_reg,
   output logic [31:0]   fail_exp,
   output logic [31:0]   fail_act,
   output logic [2:0]    state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RUN  = 3'd1,
      S_ADDR = 3'd2,
      S_CMP  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [6:0] MAX_CNT  = 7'(MAX_CHECKS);
   localparam logic [9:0] RUN_LAST = 10'((NUM_CYCLES == 0) ? 0 : NUM_CYCLES - 1);

   state_t        state;
   logic [4:0]    tbl_reg [MAX_CHECKS];
   logic [31:0]   tbl_val [MAX_CHECKS];
   logic [9:0]    cycle_cnt;
   logic [AW-1:0] idx;
   logic [AW-1:0] idx_inc;
   logic [6:0]    count_q;
   logic [6:0]    count_clamped;
   logic          mismatch;
   logic          last_entry;
   logic [6:0]    err_next;
   logic          table_open;

   assign state_dbg = state;

   always_comb begin
      count_clamped = (exp_count > MAX_CNT) ? MAX_CNT : exp_count;
      idx_inc       = idx + 1'b1;
      // Case equality so an X/Z read-back is reported as a mismatch.
      mismatch      = (data_readRegA !== tbl_val[idx]);
      last_entry    = (7'(idx) == (count_q - 7'd1));
      err_next      = error_count + 7'(mismatch);
      table_open    = (state == S_IDLE) || (state == S_DONE);
   end

   // Table RAM is deliberately not reset; it survives an aborted run.
   always_ff @(posedge clock) begin
      if (exp_we && table_open) begin
         tbl_reg[exp_waddr] <= exp_wreg;
         tbl_val[exp_waddr] <= exp_wdata;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state              <= S_IDLE;
         test_mode          <= 1'b0;
         busy               <= 1'b0;
         done               <= 1'b0;
         pass               <= 1'b0;
         error_count        <= '0;
         ctrl_readRegA_test <= '0;
         cycle_cnt          <= '0;
         idx                <= '0;
         count_q            <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  count_q     <= count_clamped;
                  error_count <= '0;
                  done        <= 1'b0;
                  pass        <= 1'b0;
                  cycle_cnt   <= '0;
                  idx         <= '0;
                  busy        <= 1'b1;
                  if (NUM_CYCLES == 0) begin
                     if (count_clamped == 7'd0) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                     end else begin
                        state              <= S_ADDR;
                        test_mode          <= 1'b1;
                        ctrl_readRegA_test <= tbl_reg[0];
                     end
                  end else begin
                     state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               cycle_cnt <= cycle_cnt + 10'd1;
               if (cycle_cnt == RUN_LAST) begin
                  if (count_q == 7'd0) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= 1'b1;
                  end else begin
                     state              <= S_ADDR;
                     test_mode          <= 1'b1;
                     ctrl_readRegA_test <= tbl_reg[idx];
                  end
               end
            end
            S_ADDR: begin
               state <= S_CMP;
            end
            S_CMP: begin
               error_count <= err_next;
               if (last_entry) begin
                  state     <= S_DONE;
                  test_mode <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  pass      <= (err_next == 7'd0);
               end else begin
                  state              <= S_ADDR;
                  idx                <= idx_inc;
                  ctrl_readRegA_test <= tbl_reg[idx_inc];
               end
            end
            default: begin
               state     <= S_IDLE;
               test_mode <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

`ifdef REG_CHECK_FAIL_LOG_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fail_valid <= 1'b0;
         fail_reg   <= '0;
         fail_exp   <= '0;
         fail_act   <= '0;
      end else begin
         fail_valid <= 1'b0;
         if ((state == S_CMP) && mismatch) begin
            fail_valid <= 1'b1;
            fail_reg   <= ctrl_readRegA_test;
            fail_exp   <= tbl_val[idx];
            fail_act   <= data_readRegA;
         end
      end
   end
`else
   assign fail_valid = 1'b0;
   assign fail_reg   = '0;
   assign fail_exp   = '0;
   assign fail_act   = '0;
`endif

endmodule

// File: tb/tb_reg_check_harness.sv
// Directed bench for reg_check_harness: vector table for the main check flow plus hand-written corner sequences.
module tb_reg_check_harness;

   localparam int MAXC = 32;
   localparam int AW   = $clog2(MAXC);

   logic          clock;
   logic          reset;
   logic          start, start0;
   logic          exp_we;
   logic [AW-1:0] exp_waddr;
   logic [4:0]    exp_wreg;
   logic [31:0]   exp_wdata;
   logic [6:0]    exp_count;
   logic [31:0]   rf [32];

   logic [31:0] data_a, data_b;
   logic        test_mode, busy, done, pass, fail_valid;
   logic [4:0]  ctrl_a, fail_reg;
   logic [6:0]  error_count;
   logic [31:0] fail_exp, fail_act;
   logic [2:0]  state_dbg;

   logic        test_mode0, busy0, done0, pass0, fail_valid0;
   logic [4:0]  ctrl_b, fail_reg0;
   logic [6:0]  error_count0;
   logic [31:0] fail_exp0, fail_act0;
   logic [2:0]  state_dbg0;

   assign data_a = rf[ctrl_a];
   assign data_b = rf[ctrl_b];

   reg_check_harness #(.NUM_CYCLES(10), .MAX_CHECKS(MAXC)) dut (
      .clock(clock), .reset(reset), .start(start), .exp_we(exp_we), .exp_waddr(exp_waddr),
      .exp_wreg(exp_wreg), .exp_wdata(exp_wdata), .exp_count(exp_count), .data_readRegA(data_a),
      .test_mode(test_mode), .ctrl_readRegA_test(ctrl_a), .busy(busy), .done(done), .pass(pass),
      .error_count(error_count), .fail_valid(fail_valid), .fail_reg(fail_reg), .fail_exp(fail_exp),
      .fail_act(fail_act), .state_dbg(state_dbg));

   reg_check_harness #(.NUM_CYCLES(0), .MAX_CHECKS(MAXC)) dut0 (
      .clock(clock), .reset(reset), .start(start0), .exp_we(exp_we), .exp_waddr(exp_waddr),
      .exp_wreg(exp_wreg), .exp_wdata(exp_wdata), .exp_count(exp_count), .data_readRegA(data_b),
      .test_mode(test_mode0), .ctrl_readRegA_test(ctrl_b), .busy(busy0), .done(done0), .pass(pass0),
      .error_count(error_count0), .fail_valid(fail_valid0), .fail_reg(fail_reg0), .fail_exp(fail_exp0),
      .fail_act(fail_act0), .state_dbg(state_dbg0));

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;
   int r_tm_lat, r_tm_cyc, r_done_lat, r_fv;

   typedef struct {
      logic [31:0] r1;
      logic [31:0] r2;
      logic [6:0]  cnt;
      int          tm_lat;
      int          tm_cyc;
      int          done_lat;
      logic        pass;
      logic [6:0]  err;
      logic [4:0]  freg;
      logic [31:0] fexp;
      logic [31:0] fact;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic write_entry(input int idx, input logic [4:0] r, input logic [31:0] v);
      @(posedge clock); #1;
      exp_we = 1'b1; exp_waddr = AW'(idx); exp_wreg = r; exp_wdata = v;
      @(posedge clock); #1;
      exp_we = 1'b0;
   endtask

   // Start a run on the NUM_CYCLES=10 instance and record latencies relative to the start-sampling edge.
   task automatic run(input logic [6:0] cnt, input bit glitch);
      int cyc;
      exp_count = cnt;
      @(posedge clock); #1 start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
      cyc = 0; r_tm_lat = -1; r_tm_cyc = 0; r_fv = 0;
      if (glitch) begin
         exp_waddr = '0; exp_wreg = 5'd31; exp_wdata = 32'hDEAD_BEEF;
      end
      while (!done && cyc < 300) begin
         @(posedge clock); #1;
         cyc++;
         if (test_mode) begin
            r_tm_cyc++;
            if (r_tm_lat < 0) r_tm_lat = cyc;
         end
         if (fail_valid) r_fv++;
         start  = glitch && (cyc == 5 || cyc == 20 || cyc == 40);
         exp_we = glitch && (cyc == 30);
      end
      start = 1'b0; exp_we = 1'b0;
      r_done_lat = cyc;
      if (!done) chk("run_timeout", 32'(done), 32'd1);
   endtask

   initial begin
      int cyc;
      start = 0; start0 = 0; exp_we = 0; exp_waddr = '0; exp_wreg = '0; exp_wdata = '0; exp_count = '0;
      for (int k = 0; k < 32; k++) rf[k] = '0;
      reset = 1'b1;
      #2 reset = 1'b0;

      vecs[0] = '{32'd5, 32'hFFFF_FFFD, 7'd2, 10, 4, 14, 1'b1, 7'd0, 5'd0, 32'd0, 32'd0};
      vecs[1] = '{32'd5, 32'd7,         7'd2, 10, 4, 14, 1'b0, 7'd1, 5'd2, 32'hFFFF_FFFD, 32'd7};
      vecs[2] = '{32'd4, 32'd7,         7'd2, 10, 4, 14, 1'b0, 7'd2, 5'd2, 32'hFFFF_FFFD, 32'd7};
      vecs[3] = '{32'd5, 32'd7,         7'd1, 10, 2, 12, 1'b1, 7'd0, 5'd0, 32'd0, 32'd0};
      vecs[4] = '{32'd5, 32'd7,         7'd0, -1, 0, 10, 1'b1, 7'd0, 5'd0, 32'd0, 32'd0};
      vecs[5] = '{32'd6, 32'hFFFF_FFFD, 7'd2, 10, 4, 14, 1'b0, 7'd1, 5'd1, 32'd5, 32'd6};

      repeat (2) @(posedge clock);
      #1;
      chk("rst_test_mode", 32'(test_mode), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_pass", 32'(pass), 0);
      chk("rst_err", 32'(error_count), 0);
      chk("rst_ctrl", 32'(ctrl_a), 0);
      chk("rst_fail_valid", 32'(fail_valid), 0);
      chk("rst_state", 32'(state_dbg), 0);
      reset = 1'b1;

      // Table {r1=5, r2=-3} against several regfile contents and counts.
      write_entry(0, 5'd1, 32'd5);
      write_entry(1, 5'd2, 32'hFFFF_FFFD);
      for (int v = 0; v < 6; v++) begin
         rf[1] = vecs[v].r1;
         rf[2] = vecs[v].r2;
         run(vecs[v].cnt, 1'b0);
         chk($sformatf("v%0d_tm_lat", v), r_tm_lat, vecs[v].tm_lat);
         chk($sformatf("v%0d_tm_cyc", v), r_tm_cyc, vecs[v].tm_cyc);
         chk($sformatf("v%0d_done_lat", v), r_done_lat, vecs[v].done_lat);
         chk($sformatf("v%0d_pass", v), 32'(pass), 32'(vecs[v].pass));
         chk($sformatf("v%0d_err", v), 32'(error_count), 32'(vecs[v].err));
         chk($sformatf("v%0d_busy", v), 32'(busy), 0);
`ifdef REG_CHECK_FAIL_LOG_EN
         chk($sformatf("v%0d_fail_pulses", v), r_fv, 32'(vecs[v].err));
         if (vecs[v].err != 0) begin
            chk($sformatf("v%0d_fail_reg", v), 32'(fail_reg), 32'(vecs[v].freg));
            chk($sformatf("v%0d_fail_exp", v), fail_exp, vecs[v].fexp);
            chk($sformatf("v%0d_fail_act", v), fail_act, vecs[v].fact);
         end
`else
         chk($sformatf("v%0d_fail_pulses", v), r_fv, 0);
         chk($sformatf("v%0d_fail_tied", v), 32'(fail_reg) | fail_exp | fail_act, 0);
`endif
      end

      // Reset pulse in the middle of CMP with three entries, then re-run on the retained table.
      rf[1] = 32'd5; rf[2] = 32'hFFFF_FFFD; rf[3] = 32'd9;
      write_entry(2, 5'd3, 32'd9);
      exp_count = 7'd3;
      @(posedge clock); #1 start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
      cyc = 0;
      while (state_dbg != 3'd3 && cyc < 40) begin
         @(posedge clock); #1;
         cyc++;
      end
      chk("abort_reached_cmp", 32'(state_dbg), 3);
      reset = 1'b0;
      #1;
      chk("abort_test_mode", 32'(test_mode), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_done", 32'(done), 0);
      chk("abort_state", 32'(state_dbg), 0);
      reset = 1'b1;
      run(7'd3, 1'b0);
      chk("rerun_tm_lat", r_tm_lat, 10);
      chk("rerun_done_lat", r_done_lat, 16);
      chk("rerun_pass", 32'(pass), 1);
      chk("rerun_err", 32'(error_count), 0);

      // Full table, over-range count, stray start and exp_we pulses during the run.
      for (int k = 1; k < 32; k++) rf[k] = (32'(k) * 32'h0101_0101) ^ 32'h5A5A_0000;
      rf[0] = '0;
      for (int j = 0; j < MAXC; j++) write_entry(j, 5'(j), rf[j]);
      run(7'd200, 1'b1);
      chk("full_tm_lat", r_tm_lat, 10);
      chk("full_tm_cyc", r_tm_cyc, 64);
      chk("full_done_lat", r_done_lat, 74);
      chk("full_pass", 32'(pass), 1);
      chk("full_err", 32'(error_count), 0);
      run(7'd1, 1'b0);
      chk("frozen_table_pass", 32'(pass), 1);
      chk("frozen_table_err", 32'(error_count), 0);

      // NUM_CYCLES=0 instance: r0 entry, ADDR right after start.
      write_entry(0, 5'd0, 32'd0);
      exp_count = 7'd1;
      @(posedge clock); #1 start0 = 1'b1;
      @(posedge clock); #1 start0 = 1'b0;
      chk("z_state_addr", 32'(state_dbg0), 2);
      chk("z_test_mode", 32'(test_mode0), 1);
      chk("z_ctrl", 32'(ctrl_b), 0);
      cyc = 0;
      while (!done0 && cyc < 20) begin
         @(posedge clock); #1;
         cyc++;
      end
      chk("z_done_lat", cyc, 2);
      chk("z_pass", 32'(pass0), 1);
      chk("z_err", 32'(error_count0), 0);
      chk("z_test_mode_off", 32'(test_mode0), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
